pc_sequencer: RTL and testbench

- Program-counter sequencer for the BatPU2 core; sits directly upstream of the call stack.
- Each accepted op selects the next PC: sequential, jump, conditional branch, call, return or halt.
- Drives the call-stack push/pop controls and push data, and consumes the call-stack output on return.
- Tracks stack depth so overflow and underflow are caught here, not silently corrupted.

---
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the BatPU2 core: selects the next PC per accepted op,
// drives the downstream call stack and tracks its depth to flag overflow/underflow.
module pc_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 16,
  parameter int RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              op_valid,
  input  logic [2:0]        op_kind,
  input  logic              cond_true,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic              op_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              cs_en,
  output logic              cs_sel,
  output logic [ADDR_W-1:0] cs_din,
  output logic              halted,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  localparam int                DEPTH_W   = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0]  PC_RST    = ADDR_W'(RESET_PC);

  localparam logic [2:0] OP_JMP = 3'd1;
  localparam logic [2:0] OP_BRH = 3'd2;
  localparam logic [2:0] OP_CAL = 3'd3;
  localparam logic [2:0] OP_RET = 3'd4;
  localparam logic [2:0] OP_HLT = 3'd5;

  typedef enum logic [1:0] {
    S_RUN,
    S_RET_WAIT,
    S_HALTED,
    S_FAULT
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [ADDR_W-1:0]    pc_inc;
  logic                 accept;

  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    cs_en    = 1'b0;
    cs_sel   = 1'b0;
    cs_din   = pc_inc;
    op_ready = (state_q == S_RUN) && !stall && !rst;
    accept   = op_valid && op_ready;

    unique case (state_q)
      S_RUN: begin
        if (accept) begin
          case (op_kind)
            OP_JMP: pc_d = target;
            OP_BRH: pc_d = cond_true ? target : pc_inc;
            OP_CAL: begin
              if (depth_q == DEPTH_MAX) begin
                ovf_d   = 1'b1;
                state_d = S_FAULT;
              end else begin
                cs_en   = 1'b1;
                cs_sel  = 1'b1;
                pc_d    = target;
                depth_d = depth_q + DEPTH_W'(1);
              end
            end
            OP_RET: begin
              if (depth_q == '0) begin
                unf_d   = 1'b1;
                state_d = S_FAULT;
              end else begin
                cs_en   = 1'b1;
                depth_d = depth_q - DEPTH_W'(1);
                state_d = S_RET_WAIT;
              end
            end
            OP_HLT:  state_d = S_HALTED;
            default: pc_d = pc_inc;  // SEQ and the reserved codes 6/7
          endcase
        end
      end
      // The stack presents the popped address one cycle after the pop edge.
      S_RET_WAIT: begin
        pc_d    = ret_addr;
        state_d = S_RUN;
      end
      default: ;  // HALTED and FAULT hold until reset
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= PC_RST;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pc              = pc_q;
  assign halted          = (state_q == S_HALTED);
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random ops, all compared
// against a queue-based PC/stack model and driven by a behavioural call stack.
module tb_pc_sequencer;

  localparam int AW = 10;
  localparam int SD = 16;

  localparam logic [2:0] K_SEQ = 3'd0, K_JMP = 3'd1, K_BRH = 3'd2,
                         K_CAL = 3'd3, K_RET = 3'd4, K_HLT = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1, stall = 1'b0, op_valid = 1'b0, cond_true = 1'b0;
  logic [2:0]    op_kind = 3'd0;
  logic [AW-1:0] target = '0, ret_addr = '0;
  logic          op_ready, cs_en, cs_sel, halted, stack_overflow, stack_underflow;
  logic [AW-1:0] pc, cs_din;

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op_valid(op_valid), .op_kind(op_kind),
    .cond_true(cond_true), .target(target), .ret_addr(ret_addr), .op_ready(op_ready),
    .pc(pc), .cs_en(cs_en), .cs_sel(cs_sel), .cs_din(cs_din), .halted(halted),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, PC, stack of return addresses, sticky flags.
  localparam int M_RUN = 0, M_RETW = 1, M_HALT = 2, M_FAULT = 3;
  int            m_mode = M_RUN;
  logic [AW-1:0] m_pc = '0, m_pending = '0;
  logic [AW-1:0] m_stack[$];
  logic          m_ovf = 1'b0, m_unf = 1'b0;

  // Behavioural call stack fed by the DUT's push/pop pulses; it drives ret_addr.
  logic [AW-1:0] cs_mem[$];

  logic          obs_ready, obs_cs_en, obs_cs_sel;
  logic [AW-1:0] obs_cs_din;

  task automatic run_cycle(input logic r, input logic s, input logic v,
                           input logic [2:0] k, input logic c, input logic [AW-1:0] t);
    logic          exp_ready, acc, is_push, is_pop;
    logic [AW-1:0] pc_inc;
    @(negedge clk);
    rst = r; stall = s; op_valid = v; op_kind = k; cond_true = c; target = t;
    if (m_mode != M_RETW) ret_addr = AW'($urandom);
    #1;
    obs_ready = op_ready; obs_cs_en = cs_en; obs_cs_sel = cs_sel; obs_cs_din = cs_din;
    pc_inc    = m_pc + 1'b1;
    exp_ready = !r && (m_mode == M_RUN) && !s;
    acc       = v && exp_ready;
    is_push   = acc && (k == K_CAL) && (m_stack.size() < SD);
    is_pop    = acc && (k == K_RET) && (m_stack.size() > 0);
    checks++;
    if (obs_ready !== exp_ready) begin
      errors++; $display("FAIL op_ready: got %b expected %b at %0t", obs_ready, exp_ready, $time);
    end
    checks++;
    if (obs_cs_en !== (is_push || is_pop)) begin
      errors++; $display("FAIL cs_en: got %b expected %b at %0t", obs_cs_en, is_push || is_pop, $time);
    end
    if (is_push || is_pop) begin
      checks++;
      if (obs_cs_sel !== is_push) begin
        errors++; $display("FAIL cs_sel: got %b expected %b at %0t", obs_cs_sel, is_push, $time);
      end
    end
    if (is_push) begin
      checks++;
      if (obs_cs_din !== pc_inc) begin
        errors++; $display("FAIL cs_din: got %0d expected %0d at %0t", obs_cs_din, pc_inc, $time);
      end
    end

    @(posedge clk);
    #1;
    if (r) cs_mem.delete();
    else if (obs_cs_en === 1'b1) begin
      if (obs_cs_sel) cs_mem.push_back(obs_cs_din);
      else if (cs_mem.size() > 0) ret_addr = cs_mem.pop_back();
    end

    if (r) begin
      m_mode = M_RUN; m_pc = '0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (m_mode == M_RETW) begin
      m_pc = m_pending; m_mode = M_RUN;
    end else if (acc) begin
      case (k)
        K_JMP: m_pc = t;
        K_BRH: m_pc = c ? t : pc_inc;
        K_CAL: if (is_push) begin m_stack.push_back(pc_inc); m_pc = t; end
               else begin m_ovf = 1'b1; m_mode = M_FAULT; end
        K_RET: if (is_pop) begin m_pending = m_stack.pop_back(); m_mode = M_RETW; end
               else begin m_unf = 1'b1; m_mode = M_FAULT; end
        K_HLT: m_mode = M_HALT;
        default: m_pc = pc_inc;
      endcase
    end

    checks++;
    if (pc !== m_pc) begin
      errors++; $display("FAIL pc: got %0d expected %0d at %0t", pc, m_pc, $time);
    end
    checks++;
    if (halted !== (m_mode == M_HALT)) begin
      errors++; $display("FAIL halted: got %b expected %b at %0t", halted, m_mode == M_HALT, $time);
    end
    checks++;
    if ({stack_overflow, stack_underflow} !== {m_ovf, m_unf}) begin
      errors++; $display("FAIL flags: got %b%b expected %b%b at %0t",
                         stack_overflow, stack_underflow, m_ovf, m_unf, $time);
    end
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 1'b0, 1'b1, K_JMP, 1'b0, 10'd77);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_ready !== 1'b0 || obs_cs_en !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got ready=%b cs_en=%b expected 0 0", obs_ready, obs_cs_en);
    end
    checks++;
    if ({pc, halted, stack_overflow, stack_underflow} !== {10'd0, 3'b000}) begin
      errors++; $display("FAIL reset_state: got pc=%0d h=%b o=%b u=%b expected 0 0 0 0",
                         pc, halted, stack_overflow, stack_underflow);
    end
  endtask

  task automatic test_seq_wrap();
    logic cs_seen = 1'b0;
    do_reset();
    for (int i = 0; i < 1023; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1, (i % 50 == 7) ? 3'd6 : K_SEQ, 1'b0, AW'($urandom));
      cs_seen |= obs_cs_en;
    end
    checks++;
    if (pc !== 10'd1023) begin
      errors++; $display("FAIL seq_top: got %0d expected 1023", pc);
    end
    run_cycle(1'b0, 1'b0, 1'b1, K_SEQ, 1'b0, '0);
    cs_seen |= obs_cs_en;
    checks++;
    if (pc !== 10'd0) begin
      errors++; $display("FAIL seq_wrap: got %0d expected 0", pc);
    end
    checks++;
    if (cs_seen !== 1'b0) begin
      errors++; $display("FAIL seq_cs_en: got %b expected 0", cs_seen);
    end
  endtask

  task automatic test_branch();
    do_reset();
    run_cycle(1'b0, 1'b0, 1'b1, K_JMP, 1'b0, 10'd5);
    run_cycle(1'b0, 1'b0, 1'b1, K_BRH, 1'b0, 10'd40);
    checks++;
    if (pc !== 10'd6) begin
      errors++; $display("FAIL brh_not_taken: got %0d expected 6", pc);
    end
    run_cycle(1'b0, 1'b0, 1'b1, K_BRH, 1'b1, 10'd40);
    checks++;
    if (pc !== 10'd40) begin
      errors++; $display("FAIL brh_taken: got %0d expected 40", pc);
    end
  endtask

  task automatic test_call_return();
    do_reset();
    run_cycle(1'b0, 1'b0, 1'b1, K_JMP, 1'b0, 10'd10);
    run_cycle(1'b0, 1'b0, 1'b1, K_CAL, 1'b0, 10'd100);
    checks++;
    if ({obs_cs_en, obs_cs_sel, obs_cs_din, pc} !== {1'b1, 1'b1, 10'd11, 10'd100}) begin
      errors++; $display("FAIL call: got en=%b sel=%b din=%0d pc=%0d expected 1 1 11 100",
                         obs_cs_en, obs_cs_sel, obs_cs_din, pc);
    end
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b1, K_SEQ, 1'b0, '0);
    run_cycle(1'b0, 1'b0, 1'b1, K_RET, 1'b0, 10'd300);
    checks++;
    if ({obs_cs_en, obs_cs_sel, pc} !== {1'b1, 1'b0, 10'd103}) begin
      errors++; $display("FAIL ret_pop: got en=%b sel=%b pc=%0d expected 1 0 103",
                         obs_cs_en, obs_cs_sel, pc);
    end
    // Stall and a presented op during RET_WAIT must not block the capture.
    run_cycle(1'b0, 1'b1, 1'b1, K_JMP, 1'b0, 10'd500);
    checks++;
    if ({obs_ready, obs_cs_en, pc} !== {1'b0, 1'b0, 10'd11}) begin
      errors++; $display("FAIL ret_wait: got ready=%b en=%b pc=%0d expected 0 0 11",
                         obs_ready, obs_cs_en, pc);
    end
    run_cycle(1'b0, 1'b0, 1'b1, K_CAL, 1'b0, 10'd200);
    run_cycle(1'b0, 1'b0, 1'b1, K_RET, 1'b0, '0);
    run_cycle(1'b1, 1'b0, 1'b1, K_SEQ, 1'b0, '0);
    checks++;
    if ({pc, obs_cs_en} !== {10'd0, 1'b0}) begin
      errors++; $display("FAIL rst_in_ret_wait: got pc=%0d en=%b expected 0 0", pc, obs_cs_en);
    end
    run_cycle(1'b0, 1'b0, 1'b0, K_SEQ, 1'b0, '0);
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_rst: got %b expected 1", obs_ready);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] frozen;
    do_reset();
    for (int i = 0; i < SD; i++) run_cycle(1'b0, 1'b0, 1'b1, K_CAL, 1'b0, AW'($urandom));
    frozen = pc;
    run_cycle(1'b0, 1'b0, 1'b1, K_CAL, 1'b0, 10'd999);
    checks++;
    if ({obs_cs_en, stack_overflow, pc} !== {1'b0, 1'b1, frozen}) begin
      errors++; $display("FAIL overflow: got en=%b ovf=%b pc=%0d expected 0 1 %0d",
                         obs_cs_en, stack_overflow, pc, frozen);
    end
    run_cycle(1'b0, 1'b0, 1'b1, K_JMP, 1'b0, 10'd3);
    checks++;
    if ({obs_ready, pc} !== {1'b0, frozen}) begin
      errors++; $display("FAIL fault_frozen: got ready=%b pc=%0d expected 0 %0d", obs_ready, pc, frozen);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    run_cycle(1'b0, 1'b0, 1'b1, K_RET, 1'b0, '0);
    checks++;
    if ({obs_cs_en, stack_underflow, pc} !== {1'b0, 1'b1, 10'd0}) begin
      errors++; $display("FAIL underflow: got en=%b unf=%b pc=%0d expected 0 1 0",
                         obs_cs_en, stack_underflow, pc);
    end
    run_cycle(1'b0, 1'b0, 1'b1, K_SEQ, 1'b0, '0);
    do_reset();
    checks++;
    if ({pc, stack_overflow, stack_underflow} !== {10'd0, 2'b00}) begin
      errors++; $display("FAIL underflow_clear: got pc=%0d o=%b u=%b expected 0 0 0",
                         pc, stack_overflow, stack_underflow);
    end
    run_cycle(1'b0, 1'b0, 1'b0, K_SEQ, 1'b0, '0);
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++; $display("FAIL underflow_ready: got %b expected 1", obs_ready);
    end
  endtask

  task automatic test_stall_halt();
    do_reset();
    run_cycle(1'b0, 1'b0, 1'b1, K_JMP, 1'b0, 10'd3);
    run_cycle(1'b0, 1'b1, 1'b1, K_JMP, 1'b0, 10'd7);
    checks++;
    if ({pc, obs_cs_en} !== {10'd3, 1'b0}) begin
      errors++; $display("FAIL stall: got pc=%0d en=%b expected 3 0", pc, obs_cs_en);
    end
    run_cycle(1'b0, 1'b0, 1'b1, K_HLT, 1'b0, '0);
    for (int i = 0; i < 5; i++)
      run_cycle(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, 4)), 1'b1, AW'($urandom));
    checks++;
    if ({halted, pc} !== {1'b1, 10'd3}) begin
      errors++; $display("FAIL halt: got halted=%b pc=%0d expected 1 3", halted, pc);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic r = ($urandom_range(0, 99) < 3);
      logic [2:0] k;
      int sel = $urandom_range(0, 99);
      k = (sel < 30) ? K_CAL : (sel < 55) ? K_RET : (sel < 57) ? K_HLT : 3'($urandom_range(0, 7));
      if (k == K_HLT && sel >= 57) k = K_SEQ;
      run_cycle(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), k,
                1'($urandom), AW'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_branch();
    test_call_return();
    test_overflow();
    test_underflow();
    test_stall_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
